// File: rtl/pll_reset_ctrl_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding,
// retry counter width and the counter sizing function.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } state_e;

    localparam int RETRY_W = 8;

    // One counter serves every timed phase, so it must hold the longest interval.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// Signal bundle between the reset sequencer (master) and the PLL wrapper /
// downstream domains (slave).
interface pll_reset_ctrl_if import pll_reset_pkg::*; #(
    parameter int NUM_DOMAINS = 3
);
    logic                   pll_locked;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst;
    logic                   ready;
    logic [RETRY_W-1:0]     retry_count;
    logic                   lock_lost;
    logic                   fail;

    modport master (
        input  pll_locked,
        output pll_rst, domain_rst, ready, retry_count, lock_lost, fail
    );

    modport slave (
        output pll_locked,
        input  pll_rst, domain_rst, ready, retry_count, lock_lost, fail
    );
endinterface

// File: rtl/pll_reset_ctrl_bit_sync.sv
// Two-flop synchronizer with synchronous reset to 0, used to bring the
// asynchronous PLL lock indication into the reference clock domain.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, then releases the
// domain resets in staggered order. Optional retry limit: PLL_RST_RETRY_LIMIT_EN.
module pll_reset_ctrl import pll_reset_pkg::*; #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 1000,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int NUM_DOMAINS        = 3,
    parameter int STAGGER_CYCLES     = 8,
    parameter int MAX_RETRIES        = 4
) (
    input  logic              refclk,
    input  logic              rst,
    pll_reset_ctrl_if.master  bus
);
    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, STAGGER_CYCLES);
    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);

    if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_STABLE_CYCLES < 1 || NUM_DOMAINS < 1 ||
        STAGGER_CYCLES < 1 || MAX_RETRIES < 1 || MAX_RETRIES > 255) begin : g_param_check
        $error("pll_reset_ctrl: illegal parameter value");
    end

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
    logic                   ready_q, ready_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   lk;
    logic                   release_step;
    logic [NUM_DOMAINS-1:0] released_next;

    bit_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (lk)
    );

    // Releasing a domain clears the lowest still-asserted bit; all-zero means done.
    assign released_next = domain_rst_q << 1;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            retry_q      <= '0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            retry_q      <= retry_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        retry_d      = retry_q;
        lock_lost_d  = lock_lost_q;
        release_step = 1'b0;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
`ifdef PLL_RST_RETRY_LIMIT_EN
                    state_d = ((int'(retry_q) + 1) == MAX_RETRIES) ? FAIL : RESET_PLL;
`else
                    state_d = RESET_PLL;
`endif
                end
            end
            STABLE, RELEASE: begin
                if (!lk) begin
                    // A dropout while still counting only restarts the wait; during release it re-pulses the PLL.
                    state_d = (state_q == STABLE) ? WAIT_LOCK : RESET_PLL;
                    cnt_d   = '0;
                end else if (cnt_q == ((state_q == STABLE) ? STB_LAST : STG_LAST)) begin
                    release_step = 1'b1;
                    cnt_d        = '0;
                    state_d      = (released_next == '0) ? RUN : RELEASE;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk) begin
                    state_d     = RESET_PLL;
                    lock_lost_d = 1'b1;
                end
            end
            FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pll_rst_d    = (state_d == RESET_PLL) || (state_d == FAIL);
        ready_d      = (state_d == RUN);
        domain_rst_d = '1;
        if (state_d == RELEASE || state_d == RUN) begin
            domain_rst_d = release_step ? released_next : domain_rst_q;
        end
    end

`ifdef PLL_RST_RETRY_LIMIT_EN
    logic fail_q, fail_d;

    always_comb begin
        fail_d = (state_d == FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign bus.fail = fail_q;
`else
    assign bus.fail = 1'b0;
`endif

    assign bus.pll_rst     = pll_rst_q;
    assign bus.domain_rst  = domain_rst_q;
    assign bus.ready       = ready_q;
    assign bus.retry_count = retry_q;
    assign bus.lock_lost   = lock_lost_q;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: timestamp-based reference model checked
// every cycle, directed scenarios with literal timing checks, then random lock traffic.
module tb_pll_reset_ctrl;

    localparam int PRC  = 16;
    localparam int LTO  = 1000;
    localparam int LSC  = 64;
    localparam int ND   = 3;
    localparam int STG  = 8;
    localparam int MAXR = 2;

`ifdef PLL_RST_RETRY_LIMIT_EN
    localparam bit EXP_FAIL = 1'b1;
`else
    localparam bit EXP_FAIL = 1'b0;
`endif

    localparam int PH_PLLRST = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_ACTIVE = 3;
    localparam int PH_FAIL   = 4;

    logic refclk = 1'b0;
    logic rst;

    pll_reset_ctrl_if #(.NUM_DOMAINS(ND)) dut_if ();

    pll_reset_ctrl #(
        .PLL_RST_CYCLES     (PRC),
        .LOCK_TIMEOUT       (LTO),
        .LOCK_STABLE_CYCLES (LSC),
        .NUM_DOMAINS        (ND),
        .STAGGER_CYCLES     (STG),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (dut_if.master)
    );

    always #10 refclk = ~refclk;

    int checks = 0;
    int errors = 0;
    int tick_n = 0;
    bit chk_en = 1'b0;

    // Model state: phase plus the edge index at which the phase began.
    int t = 0;
    int m_phase = PH_PLLRST;
    int m_start = 0;
    int m_retry = 0;
    bit m_lost = 1'b0;
    bit h1 = 1'b0;
    bit h2 = 1'b0;

    function automatic int released_at(input int tt);
        int r;
        r = 1 + (tt - m_start) / STG;
        if (r > ND) r = ND;
        return r;
    endfunction

    task automatic model_step(input bit r, input bit l);
        bit lk;
        lk = h2;
        t++;
        if (r) begin
            m_phase = PH_PLLRST;
            m_start = t;
            m_retry = 0;
            m_lost  = 1'b0;
            h1      = 1'b0;
            h2      = 1'b0;
        end else begin
            h2 = h1;
            h1 = l;
            case (m_phase)
                PH_PLLRST: if (t - m_start == PRC) begin
                    m_phase = PH_WAIT;
                    m_start = t;
                end
                PH_WAIT: begin
                    if (lk) begin
                        m_phase = PH_STABLE;
                        m_start = t;
                    end else if (t - m_start == LTO) begin
                        if (m_retry < 255) m_retry++;
                        m_phase = PH_PLLRST;
                        m_start = t;
`ifdef PLL_RST_RETRY_LIMIT_EN
                        if (m_retry == MAXR) m_phase = PH_FAIL;
`endif
                    end
                end
                PH_STABLE: begin
                    if (!lk) begin
                        m_phase = PH_WAIT;
                        m_start = t;
                    end else if (t - m_start == LSC) begin
                        m_phase = PH_ACTIVE;
                        m_start = t;
                    end
                end
                PH_ACTIVE: if (!lk) begin
                    if (released_at(t - 1) == ND) m_lost = 1'b1;
                    m_phase = PH_PLLRST;
                    m_start = t;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [ND-1:0] m_domain_rst();
        logic [ND-1:0] v;
        int rel;
        v = '1;
        if (m_phase == PH_ACTIVE) begin
            rel = released_at(t);
            for (int i = 0; i < ND; i++) v[i] = (i >= rel);
        end
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at tick %0d: got %0h, expected %0h", name, tick_n, act, exp);
        end
    endtask

    // Drive one cycle of inputs; they are sampled on the next rising edge.
    task automatic apply_stimulus(input bit r, input bit l);
        rst               = r;
        dut_if.pll_locked = l;
        @(posedge refclk);
        model_step(r, l);
        chk_en = 1'b1;
        #1;
        tick_n++;
    endtask

    task automatic hold(input bit r, input bit l, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(r, l);
    endtask

    always @(negedge refclk) begin
        if (chk_en) begin
            check_output("pll_rst",     32'(dut_if.pll_rst),     32'(m_phase == PH_PLLRST || m_phase == PH_FAIL));
            check_output("domain_rst",  32'(dut_if.domain_rst),  32'(m_domain_rst()));
            check_output("ready",       32'(dut_if.ready),       32'(m_phase == PH_ACTIVE && released_at(t) == ND));
            check_output("retry_count", 32'(dut_if.retry_count), 32'(m_retry));
            check_output("lock_lost",   32'(dut_if.lock_lost),   32'(m_lost));
            check_output("fail",        32'(dut_if.fail),        32'(m_phase == PH_FAIL));
        end
    end

    initial begin
        int f0, f1, f2, fr, rise, base, drop;
        rst               = 1'b1;
        dut_if.pll_locked = 1'b0;

        // Bring-up: lock raised in cycle 30; domain 0 falls in cycle 97 (updated on edge 96).
        hold(1, 0, 3);
        check_output("reset_pll_rst", 32'(dut_if.pll_rst), 32'd1);
        check_output("reset_domain_rst", 32'(dut_if.domain_rst), 32'h7);
        base = tick_n;
        for (int c = 0; c < 30; c++) begin
            apply_stimulus(0, 0);
            if (c == 14) check_output("pll_rst_c14", 32'(dut_if.pll_rst), 32'd1);
            if (c == 15) check_output("pll_rst_c15", 32'(dut_if.pll_rst), 32'd0);
        end
        f0 = -1; f1 = -1; f2 = -1; fr = -1;
        for (int c = 30; c < 230; c++) begin
            apply_stimulus(0, 1);
            if (f0 < 0 && dut_if.domain_rst[0] === 1'b0) f0 = c;
            if (f1 < 0 && dut_if.domain_rst[1] === 1'b0) f1 = c;
            if (f2 < 0 && dut_if.domain_rst[2] === 1'b0) f2 = c;
            if (fr < 0 && dut_if.ready === 1'b1) fr = c;
        end
        check_output("rel0_latency", 32'(f0 - 30), 32'd66);
        check_output("rel1_stagger", 32'(f1 - f0), 32'd8);
        check_output("rel2_stagger", 32'(f2 - f0), 32'd16);
        check_output("ready_with_last", 32'(fr - f2), 32'd0);
        check_output("bringup_retry", 32'(dut_if.retry_count), 32'd0);

        // Lock loss in RUN: outputs fall back on the third edge after the drop.
        drop = tick_n;
        hold(0, 0, 2);
        check_output("loss_not_yet", 32'(dut_if.domain_rst), 32'h0);
        apply_stimulus(0, 0);
        check_output("loss_domain_rst", 32'(dut_if.domain_rst), 32'h7);
        check_output("loss_ready", 32'(dut_if.ready), 32'd0);
        check_output("loss_pll_rst", 32'(dut_if.pll_rst), 32'd1);
        check_output("loss_sticky", 32'(dut_if.lock_lost), 32'd1);
        check_output("loss_latency", 32'(tick_n - drop), 32'd3);
        hold(0, 1, 150);
        check_output("relock_ready", 32'(dut_if.ready), 32'd1);
        check_output("relock_sticky", 32'(dut_if.lock_lost), 32'd1);

        // Glitch while counting stability: count restarts from the second rise.
        hold(1, 0, 2);
        hold(0, 0, 20);
        hold(0, 1, 40);
        hold(0, 0, 3);
        check_output("glitch_no_release", 32'(dut_if.domain_rst), 32'h7);
        rise = tick_n;
        f0 = -1;
        for (int c = 0; c < 200 && f0 < 0; c++) begin
            apply_stimulus(0, 1);
            if (dut_if.domain_rst[0] === 1'b0) f0 = tick_n - 1;
        end
        check_output("glitch_rel0_latency", 32'(f0 - rise), 32'd66);
        check_output("glitch_retry", 32'(dut_if.retry_count), 32'd0);

        // Reset pulse while domain_rst = 110.
        hold(0, 1, 2);
        check_output("mid_release_state", 32'(dut_if.domain_rst), 32'h6);
        apply_stimulus(1, 1);
        check_output("mid_rst_domain_rst", 32'(dut_if.domain_rst), 32'h7);
        check_output("mid_rst_pll_rst", 32'(dut_if.pll_rst), 32'd1);
        check_output("mid_rst_ready", 32'(dut_if.ready), 32'd0);
        hold(0, 1, 120);
        check_output("restart_ready", 32'(dut_if.ready), 32'd1);

        // Timeout: never locked; retries on edges 1015 and 2031 after reset release.
        hold(1, 0, 2);
        for (int c = 0; c < 2040; c++) begin
            apply_stimulus(0, 0);
            if (c == 1014) check_output("timeout_retry0", 32'(dut_if.retry_count), 32'd0);
            if (c == 1015) check_output("timeout_retry1", 32'(dut_if.retry_count), 32'd1);
            if (c == 1015) check_output("timeout_pll_rst", 32'(dut_if.pll_rst), 32'd1);
            if (c == 2031) check_output("timeout_retry2", 32'(dut_if.retry_count), 32'd2);
            if (c == 2031) check_output("fail_after_limit", 32'(dut_if.fail), 32'(EXP_FAIL));
        end
        hold(0, 1, 150);
        check_output("late_lock_ready", 32'(dut_if.ready), 32'(!EXP_FAIL));
        check_output("late_lock_pll_rst", 32'(dut_if.pll_rst), 32'(EXP_FAIL));

        // Random lock traffic with occasional reset pulses.
        hold(1, 0, 2);
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 99) < 6) begin
                hold(1, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
            end else if ($urandom_range(0, 1) == 1) begin
                hold(0, 1, $urandom_range(1, 150));
            end else begin
                hold(0, 0, $urandom_range(1, 12));
            end
        end

        chk_en = 1'b0;
        @(negedge refclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
